// File: rtl/pass_req_ctrl.sv
// Pedestrian request front-end: synchronizes and debounces a raw button, holds the
// request until green, issues a fixed-width pass pulse, then cools down with one-deep queueing.
module pass_req_ctrl #(
   parameter int DEB_CYC  = 4,
   parameter int PASS_W   = 1,
   parameter int COOL_CYC = 8,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn,
   input  logic             G,
   output logic             pass,
   output logic             pending,
   output logic             queued,
   output logic [CNT_W-1:0] pass_cnt
);

   localparam int DW   = $clog2(DEB_CYC + 1);
   localparam int TMAX = (PASS_W > COOL_CYC) ? PASS_W : COOL_CYC;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {IDLE, PENDING, ISSUE, COOLDOWN} state_t;

   state_t          state, state_nxt;
   logic            s1, s2, deb, deb_d, rise;
   logic [DW-1:0]   deb_cnt;
   logic [TW-1:0]   tmr;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         deb     <= 1'b0;
         deb_d   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         deb_d <= deb;
         // any return of s2 to the accepted level restarts the stability count
         if (s2 == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
            deb     <= s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   assign rise = deb & ~deb_d;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (rise) state_nxt = PENDING;
         PENDING:  if (G) state_nxt = ISSUE;
         ISSUE:    if (tmr == TW'(PASS_W - 1)) state_nxt = COOLDOWN;
         COOLDOWN: if (tmr == TW'(COOL_CYC - 1))
                      // a press landing on the final cooldown cycle still counts as queued
                      state_nxt = (queued | rise) ? PENDING : IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tmr      <= '0;
         queued   <= 1'b0;
         pass_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state || state == IDLE || state == PENDING)
            tmr <= '0;
         else
            tmr <= tmr + TW'(1);
         if (state == COOLDOWN && state_nxt != COOLDOWN)
            queued <= 1'b0;
         else if (rise && (state == ISSUE || state == COOLDOWN))
            queued <= 1'b1;
         if (state == PENDING && state_nxt == ISSUE && pass_cnt != '1)
            pass_cnt <= pass_cnt + CNT_W'(1);
      end
   end

   assign pass    = (state == ISSUE);
   assign pending = (state == PENDING);

endmodule

// File: tb/tb_pass_req_ctrl.sv
// Bench for pass_req_ctrl: two configurations driven in lockstep, each scoreboarded
// against a cycle-level reference model derived from the request/pulse/cooldown rules.
module tb_pass_req_ctrl;

   logic clk = 1'b0, rst = 1'b1, btn = 1'b1, G = 1'b1;
   logic p0, pd0, q0, p1, pd1, q1;
   logic [7:0] c0;
   logic [1:0] c1;

   int n_chk = 0, n_pass = 0;
   int pulses1 = 0, qseen1 = 0;
   logic p1_prev = 1'b0;

   always #5 clk = ~clk;

   pass_req_ctrl #(.DEB_CYC(4), .PASS_W(1), .COOL_CYC(8), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .btn(btn), .G(G),
      .pass(p0), .pending(pd0), .queued(q0), .pass_cnt(c0));

   pass_req_ctrl #(.DEB_CYC(4), .PASS_W(4), .COOL_CYC(16), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .btn(btn), .G(G),
      .pass(p1), .pending(pd1), .queued(q1), .pass_cnt(c1));

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // reference model: phase 0 idle, 1 waiting for green, 2 pulsing, 3 cooling
   typedef struct {
      int sh1, sh2, deb, deb_d, run, ph, left, q, cnt;
   } ms_t;

   function automatic ms_t mstep(ms_t s, bit b, bit g, bit r, int dc, int pw, int cc, int cmax);
      ms_t n;
      bit  rise;
      n = s;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      rise    = (s.deb == 1) && (s.deb_d == 0);
      n.sh1   = b;
      n.sh2   = s.sh1;
      n.deb_d = s.deb;
      if (s.sh2 == s.deb) n.run = 0;
      else if (s.run + 1 == dc) begin n.deb = s.sh2; n.run = 0; end
      else n.run = s.run + 1;
      case (s.ph)
         0: if (rise) n.ph = 1;
         1: if (g) begin
               n.ph   = 2;
               n.left = pw;
               n.cnt  = (s.cnt < cmax) ? s.cnt + 1 : cmax;
            end
         2: begin
               if (rise) n.q = 1;
               n.left = s.left - 1;
               if (n.left == 0) begin n.ph = 3; n.left = cc; end
            end
         default: begin
               n.left = s.left - 1;
               if (n.left == 0) begin
                  n.ph = (s.q != 0 || rise) ? 1 : 0;
                  n.q  = 0;
               end else if (rise) n.q = 1;
            end
      endcase
      return n;
   endfunction

   function automatic int pack_out(ms_t s, int cw);
      return ((s.ph == 2 ? 1 : 0) << (cw + 2)) | ((s.ph == 1 ? 1 : 0) << (cw + 1))
             | (s.q << cw) | s.cnt;
   endfunction

   ms_t m0 = '{default: 0}, m1 = '{default: 0};
   int  exp0_q[$], exp1_q[$];

   always @(posedge clk) begin
      m0 = mstep(m0, btn, G, rst, 4, 1, 8, 255);
      m1 = mstep(m1, btn, G, rst, 4, 4, 16, 3);
      exp0_q.push_back(pack_out(m0, 8));
      exp1_q.push_back(pack_out(m1, 2));
   end

   always @(negedge clk) begin
      if (exp0_q.size() > 0) check("sb_dut0", int'({p0, pd0, q0, c0}), exp0_q.pop_front());
      if (exp1_q.size() > 0) check("sb_dut1", int'({p1, pd1, q1, c1}), exp1_q.pop_front());
      if (p1 && !p1_prev) pulses1++;
      if (q1) qseen1++;
      p1_prev = p1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n, base;
      int sat_exp[5] = '{1, 2, 3, 3, 3};

      // reset held with button and green asserted
      cyc(3);
      check("rst_pass", int'(p0), 0);
      check("rst_pending", int'(pd0), 0);
      check("rst_queued", int'(q0), 0);
      check("rst_cnt", int'(c0), 0);
      rst = 1'b0;
      n = 0;
      while (p0 !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("latency_edges", n, 8);
      cyc(30);
      check("held_one_req", int'(c0), 1);
      btn = 1'b0;
      cyc(20);

      // bounce: 2 high / 1 low / 3 high / 1 low never debounces
      base = pulses1;
      n = int'(c0);
      for (int i = 0; i < 40; i++) begin
         btn = (i % 7 == 2 || i % 7 == 6) ? 1'b0 : 1'b1;
         cyc(1);
      end
      btn = 1'b0;
      cyc(10);
      check("bounce_cnt", int'(c0), n);
      check("bounce_pulses", pulses1 - base, 0);

      // wait for green
      G = 1'b0;
      btn = 1'b1;
      cyc(10);
      btn = 1'b0;
      cyc(50);
      check("wait_pending0", int'(pd0), 1);
      check("wait_pending1", int'(pd1), 1);
      G = 1'b1;
      cyc(40);

      // queue merge: second press lands during dut1 cooldown
      base = pulses1;
      btn = 1'b1;
      n = 0;
      while (p1 !== 1'b1 && n < 40) begin cyc(1); n++; end
      check("merge_first_pulse", int'(p1), 1);
      btn = 1'b0;
      cyc(8);
      btn = 1'b1;
      n = 0;
      while (q1 !== 1'b1 && n < 40) begin cyc(1); n++; end
      check("merge_queued", int'(q1), 1);
      btn = 1'b0;
      cyc(60);
      check("merge_pulses", pulses1 - base, 2);
      check("merge_queued_clr", int'(q1), 0);

      // reset during the second cycle of a 4-wide pulse
      btn = 1'b1;
      n = 0;
      while (p1 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      check("midrst_2nd_cycle", int'(p1), 1);
      @(negedge clk);
      rst = 1'b1;
      btn = 1'b0;
      @(posedge clk); #1;
      check("midrst_pass", int'(p1), 0);
      check("midrst_cnt", int'(c1), 0);
      @(negedge clk);
      rst = 1'b0;
      base = pulses1;
      cyc(40);
      check("midrst_no_pulse", pulses1 - base, 0);

      // saturation of the 2-bit counter
      base = pulses1;
      for (int k = 0; k < 5; k++) begin
         btn = 1'b1;
         cyc(8);
         btn = 1'b0;
         cyc(24);
         check($sformatf("sat_cnt%0d", k), int'(c1), sat_exp[k]);
      end
      check("sat_pulses", pulses1 - base, 5);

      // random phase, scoreboard only
      for (int i = 0; i < 80; i++) begin
         btn = 1'($urandom_range(0, 1));
         G   = ($urandom_range(0, 3) != 0);
         cyc($urandom_range(1, 10));
      end
      btn = 1'b0;
      G = 1'b1;
      cyc(60);
      check("final_idle_pending", int'(pd1), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
